// File: rtl/mem_pkg.sv
// Shared types and default parameters for the memory responder slice.
// Optional feature macro: MEM_RANGE_CHECK_EN (address range checking).
package mem_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DEPTH       = 1024;
  localparam int DEF_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the processor control unit and the memory responder.
// Optional feature macro: MEM_RANGE_CHECK_EN adds the err response flag.
interface mem_responder_if #(
  parameter int DATA_W = mem_pkg::DEF_DATA_W,
  parameter int ADDR_W = mem_pkg::DEF_ADDR_W
) ();
  import mem_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
`ifdef MEM_RANGE_CHECK_EN
  logic              err;
`endif

  modport master (
    output req, we, addr, wdata,
`ifdef MEM_RANGE_CHECK_EN
    input  err,
`endif
    input  ack, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
`ifdef MEM_RANGE_CHECK_EN
    output err,
`endif
    output ack, rdata, busy
  );

endinterface

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read.
// The read register can be cleared so an out-of-range load returns zero.
module mem_array #(
  parameter int DATA_W = mem_pkg::DEF_DATA_W,
  parameter int DEPTH  = mem_pkg::DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rclr_i,
  output logic [DATA_W-1:0] rdata_o
);
  import mem_pkg::*;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage has no reset so its contents survive a reset of the responder.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register holds its value until the next read or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures a request, inserts WAIT_CYCLES wait states,
// then performs the access and pulses ack for one cycle.
// Optional feature macro: MEM_RANGE_CHECK_EN (err flag for addr >= DEPTH).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic            CLK,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
`ifdef MEM_RANGE_CHECK_EN
  localparam int CAP_W = ADDR_W;
`else
  localparam int CAP_W = IDX_W;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [CAP_W-1:0]  addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CAP_W-1:0]  reqAddr;
  logic              oorNext, oorCur;
  logic              memWe, memRe, memClr;
  logic [DATA_W-1:0] memRdata;

`ifdef MEM_RANGE_CHECK_EN
  assign reqAddr = bus.addr;

  if (ADDR_W > IDX_W) begin : g_range
    assign oorNext = |addr_d[ADDR_W-1:IDX_W];
    assign oorCur  = |addr_q[ADDR_W-1:IDX_W];
  end else begin : g_norange
    assign oorNext = 1'b0;
    assign oorCur  = 1'b0;
  end
`else
  logic unusedAddrHi;
  assign unusedAddrHi = ^bus.addr;
  assign reqAddr      = bus.addr[IDX_W-1:0];
  assign oorNext      = 1'b0;
  assign oorCur       = 1'b0;
`endif

  // State register plus the captured request and wait counter.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state logic; the request is only sampled in IDLE so bus changes later are ignored.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = reqAddr;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d   = WAIT;
            waitCnt_d = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == '0) begin
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; loads are read on the edge entering RESP so rdata is valid alongside ack.
  always_comb begin
    bus.ack  = (state_q == RESP);
    bus.busy = (state_q != IDLE);
    memWe    = (state_q == RESP) && we_q && !oorCur;
    memRe    = (state_d == RESP) && !we_d && !oorNext;
    memClr   = (state_d == RESP) && !we_d && oorNext;
`ifdef MEM_RANGE_CHECK_EN
    bus.err  = (state_q == RESP) && oorCur;
`endif
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk_i   (CLK),
    .rst_ni  (reset),
    .addr_i  (addr_d[IDX_W-1:0]),
    .we_i    (memWe),
    .wdata_i (wdata_q),
    .re_i    (memRe),
    .rclr_i  (memClr),
    .rdata_o (memRdata)
  );

  assign bus.rdata = memRdata;

endmodule
